// File: rtl/audio_pkg.sv
// Shared definitions for the audio front-end blocks.
//   GAIN_W      : width of the gain register (0..256 needs 9 bits)
//   GAIN_UNITY  : gain value that passes a sample through unchanged
//   gate_state_t: noise-gate state encoding
package audio_pkg;

  localparam int GAIN_W = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } gate_state_t;

endpackage

// File: rtl/abs_sat16.sv
// Saturating magnitude of a signed 16-bit sample.
//   sample : signed input
//   mag    : |sample|, with -32768 clamped to 32767
module abs_sat16 (
  input  logic signed [15:0] sample,
  output logic        [15:0] mag
);

  always_comb begin
    if (sample == 16'sh8000) begin
      // The true magnitude 32768 does not fit a 16-bit signed range.
      mag = 16'h7fff;
    end else if (sample[15]) begin
      mag = 16'(-sample);
    end else begin
      mag = sample;
    end
  end

endmodule

// File: rtl/noise_gate.sv
// Noise gate with attack / hold / release gain envelope.
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : sample strobe; nothing advances while low
//   audio_in  : raw signed sample
//   audio_out : sample scaled by the gain held before this sample's update
//   out_valid : in_valid delayed by one cycle
//   gate_open : gain register is nonzero
module noise_gate
  import audio_pkg::*;
#(
  parameter logic signed [15:0] THRESH       = 16'sd512,
  parameter int                 ATTACK_STEP  = 32,
  parameter int                 RELEASE_STEP = 4,
  parameter int                 HOLD_SAMPLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] audio_in,
  output logic signed [15:0] audio_out,
  output logic               out_valid,
  output logic               gate_open
);

  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);

  gate_state_t       state, state_nx;
  logic [GAIN_W-1:0] gain, gain_nx;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_nx;

  logic [15:0]       mag;
  logic              loud;
  logic [GAIN_W:0]   gain_sum;
  logic [GAIN_W-1:0] gain_up;
  logic [GAIN_W-1:0] gain_dn;
  logic [CNT_W-1:0]  hold_inc;
  logic signed [24:0] in_ext;
  logic signed [24:0] gain_ext;
  logic signed [24:0] product;

  abs_sat16 u_abs (
    .sample (audio_in),
    .mag    (mag)
  );

  assign loud = (mag >= $unsigned(THRESH));

  // One extra bit on the sum so the step past unity is seen before clamping.
  assign gain_sum = {1'b0, gain} + (GAIN_W + 1)'(ATTACK_STEP);
  assign gain_up  = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[GAIN_W-1:0];
  assign gain_dn  = (gain <= GAIN_W'(RELEASE_STEP)) ? '0 : gain - GAIN_W'(RELEASE_STEP);
  assign hold_inc = hold_cnt + CNT_W'(1);

  // Gain is zero-extended so the product stays signed; 25 bits hold +/-2^23.
  assign in_ext   = {{9{audio_in[15]}}, audio_in};
  assign gain_ext = {{(25 - GAIN_W){1'b0}}, gain};
  assign product  = in_ext * gain_ext;

  assign gate_open = (gain != '0);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    gain_nx     = gain;
    hold_cnt_nx = hold_cnt;
    if (in_valid) begin
      unique case (state)
        ST_CLOSED: begin
          gain_nx = '0;
          if (loud) begin
            state_nx = ST_ATTACK;
            gain_nx  = GAIN_W'(ATTACK_STEP);
          end
        end
        ST_ATTACK: begin
          gain_nx = gain_up;
          if (gain_up == GAIN_UNITY) state_nx = ST_OPEN;
        end
        ST_OPEN: begin
          if (!loud) begin
            if (HOLD_SAMPLES <= 1) begin
              state_nx    = ST_RELEASE;
              hold_cnt_nx = '0;
            end else begin
              state_nx    = ST_HOLD;
              hold_cnt_nx = CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (loud) begin
            state_nx    = ST_OPEN;
            hold_cnt_nx = '0;
          end else if (hold_inc == CNT_W'(HOLD_SAMPLES)) begin
            // Gain is left untouched on the sample that ends the hold.
            state_nx    = ST_RELEASE;
            hold_cnt_nx = '0;
          end else begin
            hold_cnt_nx = hold_inc;
          end
        end
        ST_RELEASE: begin
          if (loud) begin
            state_nx = ST_ATTACK;
            gain_nx  = gain_up;
          end else begin
            gain_nx = gain_dn;
            if (gain_dn == '0) state_nx = ST_CLOSED;
          end
        end
        default: begin
          state_nx    = ST_CLOSED;
          gain_nx     = '0;
          hold_cnt_nx = '0;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      gain      <= gain_nx;
      hold_cnt  <= hold_cnt_nx;
      out_valid <= in_valid;
      // Arithmetic shift floors; the result always fits 16 bits since gain <= 256.
      if (in_valid) audio_out <= 16'(product >>> 8);
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// Self-checking bench for noise_gate: directed scenarios against constants
// and a randomized run against a sample-level behavioural model.
module tb_noise_gate;
  import audio_pkg::*;

  localparam int THR = 512;
  localparam int ATK = 32;
  localparam int REL = 4;
  localparam int HLD = 256;

  localparam int M_CLOSED  = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_OPEN    = 2;
  localparam int M_HOLD    = 3;
  localparam int M_RELEASE = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] audio_in = '0;
  logic signed [15:0] audio_out;
  logic               out_valid;
  logic               gate_open;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_mode = M_CLOSED;
  int m_gain = 0;
  int m_cnt  = 0;
  int m_out  = 0;
  bit m_ov   = 1'b0;

  always #5 clk = ~clk;

  noise_gate #(
    .THRESH       (16'sd512),
    .ATTACK_STEP  (ATK),
    .RELEASE_STEP (REL),
    .HOLD_SAMPLES (HLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .audio_in  (audio_in),
    .audio_out (audio_out),
    .out_valid (out_valid),
    .gate_open (gate_open)
  );

  task automatic model_step(input bit r, input bit v, input int s);
    int  mag;
    bit  loud;
    if (r) begin
      m_mode = M_CLOSED; m_gain = 0; m_cnt = 0; m_out = 0; m_ov = 1'b0;
      return;
    end
    m_ov = v;
    if (!v) return;
    mag  = (s < 0) ? -s : s;
    if (mag > 32767) mag = 32767;
    loud = (mag >= THR);
    m_out = (s * m_gain) >>> 8;
    case (m_mode)
      M_CLOSED:
        if (loud) begin m_mode = M_ATTACK; m_gain = ATK; end
      M_ATTACK: begin
        m_gain = (m_gain + ATK > 256) ? 256 : m_gain + ATK;
        if (m_gain == 256) m_mode = M_OPEN;
      end
      M_OPEN:
        if (!loud) begin m_mode = M_HOLD; m_cnt = 1; end
      M_HOLD:
        if (loud) begin
          m_mode = M_OPEN; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == HLD) begin m_mode = M_RELEASE; m_cnt = 0; end
        end
      M_RELEASE:
        if (loud) begin
          m_mode = M_ATTACK;
          m_gain = (m_gain + ATK > 256) ? 256 : m_gain + ATK;
        end else begin
          m_gain = (m_gain - REL < 0) ? 0 : m_gain - REL;
          if (m_gain == 0) m_mode = M_CLOSED;
        end
      default: ;
    endcase
  endtask

  // Drive one clock of stimulus, then sample outputs 1 time unit after the edge.
  task automatic cycle(input bit r, input bit v, input int s);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    audio_in = 16'(s);
    @(posedge clk);
    #1;
    model_step(r, v, s);
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1000);
    n_tests++;
    if (audio_out !== 16'sd0 || out_valid !== 1'b0 || gate_open !== 1'b0 ||
        dut.state !== ST_CLOSED || dut.gain !== 9'd0) begin
      n_fail++;
      $display("FAIL reset: out=%0d ov=%b open=%b state=%0d gain=%0d, expected 0 0 0 CLOSED 0",
               audio_out, out_valid, gate_open, dut.state, dut.gain);
    end
  endtask

  task automatic test_quiet;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 100);
      n_tests++;
      if (audio_out !== 16'sd0 || gate_open !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL quiet[%0d]: out=%0d open=%b ov=%b, expected 0 0 1",
                 i, audio_out, gate_open, out_valid);
      end
    end
  endtask

  task automatic test_attack;
    int exp_out;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1000);
      exp_out = (i < 8) ? i * 125 : 1000;
      n_tests++;
      if (audio_out !== 16'(exp_out) || out_valid !== 1'b1 || gate_open !== 1'b1) begin
        n_fail++;
        $display("FAIL attack[%0d]: out=%0d ov=%b open=%b, expected %0d 1 1",
                 i, audio_out, out_valid, gate_open, exp_out);
      end
      if (i == 6 || i == 7) begin
        n_tests++;
        if (dut.state !== ((i == 7) ? ST_OPEN : ST_ATTACK)) begin
          n_fail++;
          $display("FAIL attack_state[%0d]: state=%0d, expected %0d",
                   i, dut.state, (i == 7) ? ST_OPEN : ST_ATTACK);
        end
      end
    end
  endtask

  task automatic test_hold_return;
    for (int i = 0; i < 255; i++) cycle(1'b0, 1'b1, 0);
    n_tests++;
    if (dut.state !== ST_HOLD || dut.gain !== 9'd256 || audio_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL hold_255: state=%0d gain=%0d out=%0d, expected HOLD 256 0",
               dut.state, dut.gain, audio_out);
    end
    cycle(1'b0, 1'b1, 1000);
    n_tests++;
    if (dut.state !== ST_OPEN || dut.gain !== 9'd256 || audio_out !== 16'sd1000) begin
      n_fail++;
      $display("FAIL hold_return: state=%0d gain=%0d out=%0d, expected OPEN 256 1000",
               dut.state, dut.gain, audio_out);
    end
  endtask

  task automatic test_release;
    for (int i = 0; i < 256; i++) cycle(1'b0, 1'b1, 0);
    n_tests++;
    if (dut.state !== ST_RELEASE || dut.gain !== 9'd256) begin
      n_fail++;
      $display("FAIL release_entry: state=%0d gain=%0d, expected RELEASE 256",
               dut.state, dut.gain);
    end
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 0);
      n_tests++;
      if (dut.gain !== 9'(256 - REL * (i + 1)) || gate_open !== (i < 63)) begin
        n_fail++;
        $display("FAIL release_ramp[%0d]: gain=%0d open=%b, expected %0d %b",
                 i, dut.gain, gate_open, 256 - REL * (i + 1), i < 63);
      end
    end
    n_tests++;
    if (dut.state !== ST_CLOSED || gate_open !== 1'b0) begin
      n_fail++;
      $display("FAIL release_close: state=%0d open=%b, expected CLOSED 0", dut.state, gate_open);
    end
    // Re-open, fall back into RELEASE, then interrupt it with a loud sample.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1000);
    for (int i = 0; i < 256 + 5; i++) cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b1, 600);
    n_tests++;
    // 600 * 236 / 256 = 553.125 -> 553; gain 236 + 32 clamps to 256
    if (dut.state !== ST_ATTACK || dut.gain !== 9'd256 || audio_out !== 16'sd553) begin
      n_fail++;
      $display("FAIL release_reattack: state=%0d gain=%0d out=%0d, expected ATTACK 256 553",
               dut.state, dut.gain, audio_out);
    end
  endtask

  task automatic test_boundary;
    cycle(1'b0, 1'b1, 1000);
    cycle(1'b0, 1'b1, -32768);
    n_tests++;
    if (audio_out !== -16'sd32768 || dut.state !== ST_OPEN) begin
      n_fail++;
      $display("FAIL min_unity: out=%0d state=%0d, expected -32768 OPEN", audio_out, dut.state);
    end
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, (i == 1) ? -511 : 511);
    n_tests++;
    if (dut.state !== ST_CLOSED || gate_open !== 1'b0 || audio_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL thresh_511: state=%0d open=%b out=%0d, expected CLOSED 0 0",
               dut.state, gate_open, audio_out);
    end
    cycle(1'b0, 1'b1, 512);
    n_tests++;
    if (dut.state !== ST_ATTACK || dut.gain !== 9'd32 || audio_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL thresh_512: state=%0d gain=%0d out=%0d, expected ATTACK 32 0",
               dut.state, dut.gain, audio_out);
    end
  endtask

  task automatic test_stall;
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1000);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, int'($urandom_range(0, 65535)) - 32768);
      n_tests++;
      if (out_valid !== 1'b0 || audio_out !== 16'sd250 || dut.state !== ST_ATTACK ||
          dut.gain !== 9'd96) begin
        n_fail++;
        $display("FAIL stall[%0d]: ov=%b out=%0d state=%0d gain=%0d, expected 0 250 ATTACK 96",
                 i, out_valid, audio_out, dut.state, dut.gain);
      end
    end
    cycle(1'b1, 1'b1, 1000);
    n_tests++;
    if (audio_out !== 16'sd0 || out_valid !== 1'b0 || gate_open !== 1'b0 ||
        dut.state !== ST_CLOSED) begin
      n_fail++;
      $display("FAIL reset_mid_attack: out=%0d ov=%b open=%b state=%0d, expected 0 0 0 CLOSED",
               audio_out, out_valid, gate_open, dut.state);
    end
  endtask

  task automatic test_random;
    int phase;
    int mag;
    int s;
    bit v;
    bit r;
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) phase = $urandom_range(0, 3);
      case (phase)
        0:       mag = $urandom_range(THR, 32768);
        1:       mag = $urandom_range(0, THR - 1);
        2:       mag = $urandom_range(0, 2 * THR);
        default: mag = ($urandom_range(0, 99) == 0) ? $urandom_range(THR, 32768)
                                                    : $urandom_range(0, THR - 1);
      endcase
      s = ($urandom_range(0, 1) == 1) ? -mag : mag;
      if (s == 32768) s = 32767;
      v = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 999) == 0);
      cycle(r, v, s);
      n_tests++;
      if (audio_out !== 16'(m_out) || out_valid !== m_ov || gate_open !== (m_gain != 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%0d ov=%b open=%b, expected %0d %b %b",
                 i, audio_out, out_valid, gate_open, m_out, m_ov, m_gain != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_quiet();
    test_attack();
    test_hold_return();
    test_release();
    test_boundary();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_gate.md
NOISE_GATE -- requirements
Module: noise_gate

Interface
REQ-001 SHALL have parameter THRESH, default 16'sd512, the open/close magnitude threshold.
REQ-002 SHALL have parameter ATTACK_STEP, default 32, the gain increment per valid sample.
REQ-003 SHALL have parameter RELEASE_STEP, default 4, the gain decrement per valid sample.
REQ-004 SHALL have parameter HOLD_SAMPLES, default 256, the number of consecutive sub-threshold samples tolerated before release.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, the sample strobe.
REQ-008 SHALL have port audio_in, input, signed 16 bits, the raw sample; it is sampled only when in_valid=1.
REQ-009 SHALL have port audio_out, output, signed 16 bits, the gated sample; it feeds the echo stage.
REQ-010 SHALL have port out_valid, output, 1 bit, asserted when audio_out carries a new sample.
REQ-011 SHALL have port gate_open, output, 1 bit, high whenever the gain register is nonzero.

Function
REQ-012 SHALL compute mag = |audio_in|, saturating -32768 to 32767.
REQ-013 SHALL keep a 9-bit unsigned gain register, range 0..256, where 256 means unity.
REQ-014 SHALL implement a five-state machine: CLOSED, ATTACK, OPEN, HOLD, RELEASE.
REQ-015 SHALL make state, gain, hold counter and outputs change only on cycles with in_valid=1, except under reset.
REQ-016 SHALL, in CLOSED: if mag>=THRESH, go to ATTACK with gain=ATTACK_STEP; otherwise hold gain at 0.
REQ-017 SHALL, in ATTACK: set gain=min(gain+ATTACK_STEP,256) regardless of mag, and go to OPEN on the sample where gain becomes 256.
REQ-018 SHALL, in OPEN: if mag<THRESH, go to HOLD with hold counter=1; otherwise stay in OPEN.
REQ-019 SHALL, in HOLD: if mag>=THRESH, go to OPEN with counter=0; otherwise increment the counter.
REQ-020 SHALL, in HOLD, go to RELEASE after the sample on which the counter reaches HOLD_SAMPLES, with gain unchanged on that sample.
REQ-021 SHALL, in RELEASE: if mag>=THRESH, go to ATTACK and apply the step on that same sample.
REQ-022 SHALL, in RELEASE with mag<THRESH: set gain=max(gain-RELEASE_STEP,0), and go to CLOSED when gain becomes 0.
REQ-023 SHALL compute audio_out = (audio_in * gain_current) >>> 8, where gain_current is the gain before that sample's update; the product is 25-bit signed, the shift is arithmetic (floor), and the result is truncated to 16 bits, which is lossless because gain<=256.
REQ-024 SHALL have a latency of 1 clock: audio_out and out_valid are registered, and out_valid is in_valid delayed by one cycle.
REQ-025 SHALL keep audio_out at its last value while out_valid=0.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state=CLOSED, gain=0, hold counter=0, audio_out=0, out_valid=0 and gate_open=0.
REQ-027 SHALL give rst priority over in_valid, and a reset in any state, including mid-ATTACK or mid-RELEASE, SHALL take effect on that edge.

Structure
REQ-028 SHALL take the state encoding localparams, GAIN_W=9 and GAIN_UNITY=256 from the shared package audio_pkg.
REQ-029 SHALL contain one sub-module, abs_sat16, the combinational saturating magnitude; everything else is inline.
REQ-030 SHALL size the hold counter at $clog2(HOLD_SAMPLES+1) bits.

Verification
REQ-031 SHALL verify: reset, then 10 valid samples of 100 -> audio_out=0 and gate_open=0 throughout.
REQ-032 SHALL verify: from CLOSED, constant 1000 -> outputs 0,125,250,...,875, then 1000 from the 9th sample onward, with OPEN reached after the 8th.
REQ-033 SHALL verify: OPEN, then 255 zeros, then 1000 -> state returns to OPEN, gain stays 256, and the output is 1000.
REQ-034 SHALL verify: OPEN, then 256 zeros -> RELEASE; 64 further zeros -> gain 0, CLOSED, gate_open=0; a 600 sample during RELEASE -> ATTACK.
REQ-035 SHALL verify: -32768 at unity gain -> audio_out=-32768; 511 from CLOSED -> stays CLOSED; 512 -> ATTACK.
REQ-036 SHALL verify: in_valid held low for 20 cycles mid-ATTACK -> no state or gain change and out_valid=0; rst pulsed mid-ATTACK -> next cycle all outputs 0 and state CLOSED.
